alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter: WIDTH, 8, data width of operands, ALU buses and result.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: op_valid  input  1  requester presents an operation.
REQ-005 Port: op_ready  output  1  sequencer accepts an operation this cycle.
REQ-006 Port: op_code  input  3  0 ADD, 1 SHL, 2 SHR, 3 NOT, 4 AND, 5 OR, 6 XOR, 7 illegal.
REQ-007 Port: op_a  input  WIDTH  operand A, driven to the ALU's CPU bus.
REQ-008 Port: op_b  input  WIDTH  operand B, loaded into the ALU temp register.
REQ-009 Port: use_carry  input  1  feed the stored carry flag into the ALU carry-in.
REQ-010 Port: alu_cpu_bus  output  WIDTH  ALU operand A.
REQ-011 Port: alu_temp  output  WIDTH  ALU operand B (temp register).
REQ-012 Port: alu_cin  output  1  ALU carry-in.
REQ-013 Port: alu_sel  output  8  one-hot ALU unit enable; bit index equals op_code; bit 7 always 0.
REQ-014 Port: alu_acc  input  WIDTH  ALU result bus.
REQ-015 Port: alu_gr, alu_e, alu_c, alu_z  input  1 each  ALU greater, equal, carry and zero flags.
REQ-016 Port: done  output  1  one-cycle pulse: result and flags valid.
REQ-017 Port: err  output  1  qualifies done: operation was illegal.
REQ-018 Port: result  output  WIDTH  registered ALU result.
REQ-019 Port: flags  output  4  registered {gr, e, c, z}.

Function
REQ-020 FSM states IDLE, LOAD, EXEC, WB; op_ready = 1 only in IDLE.
REQ-021 Accept when op_valid & op_ready; latch op_code, op_a, op_b and use_carry; legal code -> LOAD, code 7 -> WB with err.
REQ-022 LOAD: alu_temp = latched op_b, alu_sel = 0; next state EXEC.
REQ-023 EXEC: alu_cpu_bus = latched op_a, alu_sel = one-hot(op_code), alu_cin = use_carry & flags.c; at the closing edge, sample alu_acc into result and {alu_gr, alu_e, alu_c, alu_z} into flags; next state WB.
REQ-024 WB: done = 1, err = (code 7); next state IDLE unconditionally.
REQ-025 Latency: acceptance in cycle N -> done in cycle N+3 (legal) or N+1 (illegal); throughput is one op per 4 cycles.
REQ-026 alu_sel SHALL be all-zero in every state except EXEC, and never has more than one bit set.
REQ-027 Illegal op: result and flags are unchanged; no ALU unit is enabled.
REQ-028 Outside EXEC, alu_cpu_bus and alu_temp hold their last driven values; alu_cin = 0.
REQ-029 op_valid asserted outside IDLE is ignored; the operation is not accepted and does not corrupt latched operands.
REQ-030 The carry used is the flag value before the current op; back-to-back ops chain carry through flags.c.

Reset
REQ-031 rst asserted at any edge, including mid-operation: state -> IDLE; result = 0, flags = 0, alu_sel = 0, alu_cin = 0, alu_cpu_bus = 0, alu_temp = 0, done = 0, err = 0.
REQ-032 An operation interrupted by reset produces no done pulse; op_ready = 1 in the first cycle after rst deasserts.

Structure
REQ-033 Shared package alu_ctrl_pkg holds the state enum, the opcode constants (OP_ADD to OP_XOR, OP_ILL) and the flag bit indices.
REQ-034 One sub-module alu_sel_decode: combinational 3-bit opcode plus enable to 8-bit one-hot, with bit 7 forced to 0.

Verification
REQ-035 ADD: a=0x0F, b=0x01, use_carry=0, ALU model returns 0x10 -> alu_sel=0x01 only in EXEC; done at N+3; result=0x10; flags.z=0.
REQ-036 Carry chain: ADD 0xFF+0x01 (model c=1, z=1), then ADD 0x00+0x00 with use_carry=1 -> second op shows alu_cin=1 in EXEC; flags after op 1 = c=1, z=1.
REQ-037 Illegal: op_code=7 -> done and err at N+1; alu_sel stays 0x00; result and flags unchanged.
REQ-038 Busy: hold op_valid=1 continuously with 3 different ops -> ops accepted exactly every 4 cycles in order; one done per op.
REQ-039 Reset mid-op: assert rst during EXEC of XOR (alu_sel=0x40) -> next cycle alu_sel=0, result=0, no done; op_ready=1 after release.
REQ-040 Sweep opcodes 0 to 6 -> alu_sel in EXEC equals 1<<op_code; $onehot0(alu_sel) holds every cycle.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU operation sequencer: FSM states, opcodes
// and the bit positions of the {gr, e, c, z} flag vector.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SHL = 3'd1;
  localparam logic [2:0] OP_SHR = 3'd2;
  localparam logic [2:0] OP_NOT = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  localparam int FLAG_Z  = 0;
  localparam int FLAG_C  = 1;
  localparam int FLAG_E  = 2;
  localparam int FLAG_GR = 3;

endpackage

// File: rtl/alu_sel_decode.sv
// Opcode to one-hot ALU unit enable; the illegal code never enables a unit,
// so bit 7 is always 0.
module alu_sel_decode
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] code,
  input  logic       en,
  output logic [7:0] sel
);

  // one-hot decode gated by enable
  always_comb begin
    sel = 8'h00;
    if (en && (code != OP_ILL)) begin
      sel = 8'h01 << code;
    end else begin
      sel = 8'h00;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation through IDLE -> LOAD -> EXEC -> WB, driving the
// ALU operand buses and unit enable, and capturing the result and flags.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             use_carry,
  output logic [WIDTH-1:0] alu_cpu_bus,
  output logic [WIDTH-1:0] alu_temp,
  output logic             alu_cin,
  output logic [7:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_acc,
  input  logic             alu_gr,
  input  logic             alu_e,
  input  logic             alu_c,
  input  logic             alu_z,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  state_t           state;
  state_t           next_state;
  logic [2:0]       code_q;
  logic [WIDTH-1:0] a_q;
  logic             use_carry_q;
  logic [7:0]       sel_next;
  logic             exec_next;

  assign exec_next = (next_state == ST_EXEC);

  alu_sel_decode u_sel_decode (
    .code (code_q),
    .en   (exec_next),
    .sel  (sel_next)
  );

  // next-state logic; an illegal opcode skips straight to write-back
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (op_valid) begin
          next_state = (op_code == OP_ILL) ? ST_WB : ST_LOAD;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_LOAD: next_state = ST_EXEC;
      ST_EXEC: next_state = ST_WB;
      ST_WB:   next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // outputs are registered from next_state so they line up with the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_ready    <= 1'b1;
      code_q      <= 3'd0;
      a_q         <= '0;
      use_carry_q <= 1'b0;
      alu_cpu_bus <= '0;
      alu_temp    <= '0;
      alu_cin     <= 1'b0;
      alu_sel     <= 8'h00;
      done        <= 1'b0;
      err         <= 1'b0;
      result      <= '0;
      flags       <= 4'h0;
    end else begin
      state    <= next_state;
      op_ready <= (next_state == ST_IDLE);
      alu_sel  <= sel_next;
      alu_cin  <= exec_next & use_carry_q & flags[FLAG_C];
      done     <= (next_state == ST_WB);
      // IDLE -> WB happens only for the illegal opcode
      err      <= (state == ST_IDLE) && (next_state == ST_WB);
      if ((state == ST_IDLE) && op_valid) begin
        code_q      <= op_code;
        a_q         <= op_a;
        use_carry_q <= use_carry;
      end
      if (next_state == ST_LOAD) begin
        alu_temp <= op_b;
      end
      if (exec_next) begin
        alu_cpu_bus <= a_q;
      end
      if (state == ST_EXEC) begin
        result <= alu_acc;
        flags  <= {alu_gr, alu_e, alu_c, alu_z};
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized scoreboard bench for alu_op_sequencer with a behavioural ALU and
// a transaction-level model of acceptance, latency and carry chaining.
module tb_alu_op_sequencer;

  typedef struct {
    logic [7:0] res;
    logic [3:0] fl;
    logic       err;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [2:0] op_code = 3'd0;
  logic [7:0] op_a = 8'h00;
  logic [7:0] op_b = 8'h00;
  logic       use_carry = 1'b0;
  logic [7:0] alu_cpu_bus, alu_temp, alu_acc, result;
  logic       alu_cin, alu_gr, alu_e, alu_c, alu_z, done, err;
  logic [7:0] alu_sel;
  logic [3:0] flags;

  alu_op_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_a(op_a), .op_b(op_b), .use_carry(use_carry),
    .alu_cpu_bus(alu_cpu_bus), .alu_temp(alu_temp), .alu_cin(alu_cin),
    .alu_sel(alu_sel), .alu_acc(alu_acc), .alu_gr(alu_gr), .alu_e(alu_e),
    .alu_c(alu_c), .alu_z(alu_z), .done(done), .err(err),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU behaviour: returns {result, gr, e, c, z}
  function automatic logic [11:0] alu_fn(input logic [2:0] c, input logic [7:0] a,
                                         input logic [7:0] b, input logic ci);
    logic [8:0] s;
    logic [7:0] r;
    logic       co;
    s  = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    r  = 8'h00;
    co = 1'b0;
    case (c)
      3'd0: begin r = s[7:0]; co = s[8]; end
      3'd1: begin r = {a[6:0], 1'b0}; co = a[7]; end
      3'd2: begin r = {1'b0, a[7:1]}; co = a[0]; end
      3'd3: r = ~a;
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = 8'h00;
    endcase
    return {r, (a > b), (a == b), co, (r == 8'h00)};
  endfunction

  // environment ALU: junk on the result bus whenever no unit is enabled
  always_comb begin
    {alu_acc, alu_gr, alu_e, alu_c, alu_z} = {8'hA5, 4'b1010};
    for (int i = 0; i < 7; i++) begin
      if (alu_sel[i]) {alu_acc, alu_gr, alu_e, alu_c, alu_z} = alu_fn(3'(i), alu_cpu_bus, alu_temp, alu_cin);
    end
  end

  int         total = 0;
  int         bad = 0;
  exp_t       q[$];
  exp_t       e;
  logic       exp_ready = 1'b1;
  int         busy = 0;
  int         exec_cyc = -1;
  logic [7:0] exec_sel = 8'h00, exec_a = 8'h00, exec_b = 8'h00;
  logic       exec_cin = 1'b0;
  logic [7:0] m_res = 8'h00;
  logic [3:0] m_flags = 4'h0;
  logic       rst_prev = 1'b0;
  bit         mon_en = 1'b0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", n, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_res    = 8'h00;
    m_flags  = 4'h0;
    busy     = 0;
    exec_cyc = -1;
    mon_en   = 1'b1;
  endtask

  // one clock cycle of stimulus; called just after a rising edge
  task automatic step(input logic r, input logic v, input logic [2:0] c,
                      input logic [7:0] a, input logic [7:0] b, input logic u);
    logic        ci;
    logic [11:0] rr;
    if (rst_prev) model_reset();
    rst = r; op_valid = v; op_code = c; op_a = a; op_b = b; use_carry = u;
    exp_ready = (busy == 0);
    if (!r && v && busy == 0) begin
      if (c == 3'd7) begin
        q.push_back('{m_res, m_flags, 1'b1, cyc + 1});
        busy = 1;
      end else begin
        ci = u & m_flags[1];
        rr = alu_fn(c, a, b, ci);
        m_res = rr[11:4];
        m_flags = rr[3:0];
        q.push_back('{m_res, m_flags, 1'b0, cyc + 3});
        busy = 3;
        exec_cyc = cyc + 2;
        exec_sel = 8'h01 << c;
        exec_a = a;
        exec_b = b;
        exec_cin = ci;
      end
    end else if (busy > 0) begin
      busy--;
    end
    if (rst_prev) begin
      @(negedge clk);
      chk("rst_result", result, 32'h0);
      chk("rst_flags", flags, 32'h0);
      chk("rst_sel", alu_sel, 32'h0);
      chk("rst_cin", alu_cin, 32'h0);
      chk("rst_cpu_bus", alu_cpu_bus, 32'h0);
      chk("rst_temp", alu_temp, 32'h0);
      chk("rst_done", done, 32'h0);
      chk("rst_err", err, 32'h0);
    end
    rst_prev = r;
    @(posedge clk);
    #1;
  endtask

  // present an op until accepted; while busy, drive other (ignored) traffic
  task automatic issue(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b,
                       input logic u, input bit hold);
    for (int k = 0; k < 8 && busy != 0; k++) begin
      step(1'b0, hold ? 1'b1 : 1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    end
    step(1'b0, 1'b1, c, a, b, u);
  endtask

  // monitor: handshake, per-state ALU drive and done/result scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      chk("op_ready", op_ready, exp_ready);
      chk("sel_onehot0", 32'($onehot0(alu_sel)), 32'h1);
      if (cyc == exec_cyc) begin
        chk("exec_sel", alu_sel, exec_sel);
        chk("exec_cin", alu_cin, exec_cin);
        chk("exec_cpu_bus", alu_cpu_bus, exec_a);
        chk("exec_temp", alu_temp, exec_b);
      end else begin
        chk("idle_sel", alu_sel, 32'h0);
        chk("idle_cin", alu_cin, 32'h0);
      end
      if (done) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("done_latency", cyc, e.due);
          chk("result", result, e.res);
          chk("flags", flags, e.fl);
          chk("err", err, e.err);
        end
      end else begin
        chk("err_without_done", err, 32'h0);
        if (q.size() > 0 && q[0].due <= cyc) begin
          total++; bad++;
          $display("FAIL missing_done actual=0 required=1 (cycle %0d)", cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #1;
    step(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    // directed: ADD, carry chain, illegal
    issue(3'd0, 8'h0F, 8'h01, 1'b0, 1'b0);
    issue(3'd0, 8'hFF, 8'h01, 1'b0, 1'b0);
    issue(3'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    issue(3'd7, 8'h12, 8'h34, 1'b1, 1'b0);
    // busy: valid held high across three ops
    issue(3'd4, 8'hF0, 8'h3C, 1'b0, 1'b1);
    issue(3'd5, 8'h0A, 8'h50, 1'b0, 1'b1);
    issue(3'd1, 8'h81, 8'h00, 1'b0, 1'b1);
    // reset during EXEC of an XOR
    issue(3'd6, 8'h5A, 8'hFF, 1'b0, 1'b1);
    step(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    // opcode sweep
    for (int c = 0; c < 7; c++) begin
      issue(3'(c), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    end
    // random traffic
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      issue(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    repeat (6) step(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    chk("queue_drained", q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
